// File: rtl/fir_i2s_tx.sv
// Output stage behind the FIR filter: round/saturate to W bits, buffer in a
// small FIFO and transmit as a mono-duplicated I2S stream.
module fir_i2s_tx #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 15,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic [IN_WIDTH-1:0]           in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BW = $clog2(2 * OUT_WIDTH);
    localparam int SW = 2 * OUT_WIDTH;

    localparam logic [IN_WIDTH:0]        HALF = (IN_WIDTH + 1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_WIDTH:0] MAXV = $signed((IN_WIDTH + 1)'(2 ** (OUT_WIDTH - 1) - 1));
    localparam logic signed [IN_WIDTH:0] MINV = ~MAXV;

    logic signed [IN_WIDTH:0] sum, r;
    logic [OUT_WIDTH-1:0]     in_word, word;

    logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 full, empty, push, pop;

    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [SW-1:0] shreg_q, shreg_d;
    logic          bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d, underrun_q, underrun_d;
    logic          div_wrap, fall, frame_load;

    // Requantize in IN_WIDTH+1 bits so the rounding offset can never overflow.
    always_comb begin
        sum = {in_data[IN_WIDTH-1], in_data} + HALF;
        r   = sum >>> SHIFT;
        if (r > MAXV)
            in_word = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else if (r < MINV)
            in_word = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            in_word = r[OUT_WIDTH-1:0];
    end

    always_comb begin
        full       = (level_q == LW'(FIFO_DEPTH));
        empty      = (level_q == '0);
        div_wrap   = (div_q == DW'(BCLK_DIV - 1));
        fall       = div_wrap & bclk_q;
        frame_load = fall & (bit_cnt_q == BW'(SW - 1));
        push       = in_valid & ~full;
        pop        = frame_load & ~empty;
        word       = pop ? mem_q[rd_ptr_q] : '0;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push)
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        div_d      = div_wrap ? '0 : div_q + 1'b1;
        bclk_d     = div_wrap ? ~bclk_q : bclk_q;
        bit_cnt_d  = bit_cnt_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        shreg_d    = shreg_q;
        underrun_d = frame_load & empty;
        // All serial outputs move together on the bclk falling edge.
        if (fall) begin
            bit_cnt_d = frame_load ? '0 : bit_cnt_q + 1'b1;
            lrclk_d   = (bit_cnt_d >= BW'(OUT_WIDTH));
            sdata_d   = shreg_q[SW-1];
            shreg_d   = frame_load ? {word, word} : shreg_q << 1;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            div_q      <= '0;
            bit_cnt_q  <= BW'(SW - 1);
            shreg_q    <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem_q[wr_ptr_q] <= in_word;
    end

    assign in_ready   = ~full;
    assign fifo_level = level_q;
    assign bclk       = bclk_q;
    assign lrclk      = lrclk_q;
    assign sdata      = sdata_q;
    assign underrun   = underrun_q;

endmodule
